// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive frame sequencer: FSM states and error codes.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DRAIN
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2,
    ERR_TO   = 2'd3
  } err_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 register file, one synchronous write port, combinational read.
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [DEPTH];

  // Pure data storage: left unreset, the control path never reads a slot before writing it.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame sequencer behind the UART byte receiver: parses HEADER/LEN/payload/CSUM,
// buffers the payload and streams it out only once the checksum has matched.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000,
  parameter int         TO_W        = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_valid_i,
  input  logic [7:0] rx_data_i,
  output logic       out_valid_o,
  output logic [7:0] out_data_o,
  output logic       out_last_o,
  input  logic       out_ready_i,
  output logic       frame_ok_o,
  output logic       frame_err_o,
  output logic [1:0] err_code_o,
  output logic       busy_o
);

  localparam int PTR_W = $clog2(MAX_LEN);

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              frame_ok_q, frame_ok_d;
  logic              frame_err_q, frame_err_d;
  err_e              err_code_q, err_code_d;

  logic              buf_we;
  logic [7:0]        buf_rdata;
  logic              wr_last, rd_last, timed_out;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (PTR_W)
  ) u_buf (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (rx_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_rdata)
  );

  assign wr_last   = (9'(wr_ptr_q) == 9'(len_q) - 9'd1);
  assign rd_last   = (9'(rd_ptr_q) == 9'(len_q) - 9'd1);
  // An arriving byte always beats expiry, so expiry is only checked on idle cycles.
  assign timed_out = !rx_valid_i && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    if (rx_valid_i || state_q == ST_IDLE || state_q == ST_DRAIN) to_cnt_d = '0;
    else                                                        to_cnt_d = to_cnt_q + TO_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid_i && rx_data_i == HEADER) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (rx_valid_i) begin
          if (rx_data_i == 8'd0 || int'(rx_data_i) > MAX_LEN) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = ST_IDLE;
          end else begin
            len_d    = rx_data_i;
            sum_d    = rx_data_i;
            wr_ptr_d = '0;
            state_d  = ST_PAYLOAD;
          end
        end else if (timed_out) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TO;
          state_d     = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (rx_valid_i) begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_data_i;
          if (wr_last) state_d  = ST_CSUM;
          else         wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else if (timed_out) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TO;
          state_d     = ST_IDLE;
        end
      end
      ST_CSUM: begin
        if (rx_valid_i) begin
          if (rx_data_i == sum_q) begin
            frame_ok_d = 1'b1;
            rd_ptr_d   = '0;
            state_d    = ST_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CSUM;
            state_d     = ST_IDLE;
          end
        end else if (timed_out) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TO;
          state_d     = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // A byte arriving while draining is an overrun: drop it, keep streaming.
        if (rx_valid_i) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TO;
        end
        if (out_ready_i) begin
          if (rd_last) state_d  = ST_IDLE;
          else         rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      to_cnt_q    <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      to_cnt_q    <= to_cnt_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Buffer contents are unreset, so data is forced to zero whenever nothing is offered.
  assign out_valid_o = (state_q == ST_DRAIN);
  assign out_data_o  = out_valid_o ? buf_rdata : 8'h00;
  assign out_last_o  = out_valid_o && rd_last;
  assign frame_ok_o  = frame_ok_q;
  assign frame_err_o = frame_err_q;
  assign err_code_o  = err_code_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Scoreboard bench for uart_rx_frame_ctrl: stimulus pushes expected stream bytes and
// frame events into queues; a negedge monitor pops and compares as the DUT produces them.
module tb_uart_rx_frame_ctrl;

  localparam int TO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       out_ready = 1'b1;
  logic       out_valid, out_last, frame_ok, frame_err, busy;
  logic [7:0] out_data;
  logic [1:0] err_code;

  int n_tests = 0;
  int n_fail  = 0;
  bit toggle_en = 1'b0;

  typedef struct packed {logic [7:0] data; logic last;} out_t;
  typedef struct packed {logic is_err; logic [1:0] code;} evt_t;
  out_t exp_out[$];
  evt_t exp_evt[$];

  uart_rx_frame_ctrl #(
    .HEADER      (8'hA5),
    .MAX_LEN     (16),
    .TIMEOUT_CYC (TO),
    .TO_W        (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .out_ready_i (out_ready),
    .frame_ok_o  (frame_ok),
    .frame_err_o (frame_err),
    .err_code_o  (err_code),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp_o(input logic [7:0] d, input logic l);
    exp_out.push_back('{data: d, last: l});
  endtask

  task automatic exp_e(input logic e, input logic [1:0] c);
    exp_evt.push_back('{is_err: e, code: c});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"},  out_last,  0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_frame_ok"},  frame_ok,  0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_err_code"},  err_code,  0);
    check({tag, "_busy"},      busy,      0);
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_en ? ~out_ready : 1'b1;
    end
  end

  initial begin : monitor
    logic       stalled_prev;
    logic [7:0] data_prev;
    out_t       eo;
    evt_t       ee;
    stalled_prev = 1'b0;
    data_prev    = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) begin
          check("stall_valid", out_valid, 1);
          check("stall_data", out_data, data_prev);
        end
        stalled_prev = out_valid && !out_ready;
        data_prev    = out_data;
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL out_unexpected: got byte %0h, none expected", out_data);
          end else begin
            eo = exp_out.pop_front();
            check("out_data", out_data, eo.data);
            check("out_last", out_last, eo.last);
          end
        end
        if (frame_ok || frame_err) begin
          check("ok_err_exclusive", frame_ok && frame_err, 0);
          if (exp_evt.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL evt_unexpected: got ok=%0d err=%0d code=%0d, none expected",
                     frame_ok, frame_err, err_code);
          end else begin
            ee = exp_evt.pop_front();
            check("evt_is_err", frame_err, ee.is_err);
            if (ee.is_err) check("err_code", err_code, ee.code);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Good 3-byte frame, ready tied high
    exp_e(0, 0);
    exp_o(8'h11, 0); exp_o(8'h22, 0); exp_o(8'h33, 1);
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
    idle(6);
    check("busy_after_drain", busy, 0);

    // Checksum error
    exp_e(1, 2);
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
    idle(3);
    check("err_code_held", err_code, 2);

    // Bad lengths, then a good 1-byte frame
    exp_e(1, 1);
    send(8'hA5); send(8'h00);
    idle(2);
    exp_e(1, 1);
    send(8'hA5); send(8'h11);
    idle(2);
    exp_e(0, 0); exp_o(8'h7E, 1);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    idle(4);

    // Timeout mid-payload, next frame starts right after expiry
    exp_e(1, 3);
    send(8'hA5); send(8'h02); send(8'h10);
    idle(TO);
    exp_e(0, 0); exp_o(8'h7E, 1);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    idle(4);

    // Byte arriving exactly on the expiry cycle wins
    send(8'hA5); send(8'h02); send(8'h10);
    idle(TO - 1);
    exp_e(0, 0); exp_o(8'h10, 0); exp_o(8'h20, 1);
    send(8'h20); send(8'h32);
    idle(4);

    // 4-byte frame with backpressure
    toggle_en = 1'b1;
    exp_e(0, 0);
    exp_o(8'hDE, 0); exp_o(8'hAD, 0); exp_o(8'hBE, 0); exp_o(8'hEF, 1);
    send(8'hA5); send(8'h04); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF); send(8'h3C);
    idle(12);
    toggle_en = 1'b0;
    idle(2);

    // Overrun during drain; stream must stay intact
    toggle_en = 1'b1;
    exp_e(0, 0);
    exp_o(8'h01, 0); exp_o(8'h02, 0); exp_o(8'h03, 0); exp_o(8'h04, 1);
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h0E);
    exp_e(1, 3);
    send(8'h55);
    idle(12);
    toggle_en = 1'b0;
    idle(2);

    // Async reset mid-payload, then recovery
    send(8'hA5); send(8'h05); send(8'h01); send(8'h02);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h00);
    exp_e(0, 0); exp_o(8'hFF, 1);
    send(8'hA5); send(8'h01); send(8'hFF); send(8'h00);
    idle(6);

    check("out_queue_drained", exp_out.size(), 0);
    check("evt_queue_drained", exp_evt.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
